// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the writeback port arbiter.
// Replaces the old defines.v macros with typed package items.
package wb_port_arbiter_pkg;

    localparam int RegAddrW = 5;
    localparam int RegDataW = 32;

    typedef logic [RegAddrW-1:0] RegAddrBus;
    typedef logic [RegDataW-1:0] RegBus;

    localparam RegBus     ZeroWord     = '0;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;
    localparam RegAddrBus NOPRegAddr   = '0;
    localparam logic      RstEnable_n  = 1'b0;
    localparam int        WbFifoDepth  = 4;
    localparam int        WbStarveMax  = 8;

    // Source of the register-file write chosen in a given cycle
    typedef enum logic [1:0] {
        WB_SEL_NONE,
        WB_SEL_PIPE,
        WB_SEL_FIFO,
        WB_SEL_BYPASS
    } wb_sel_e;

endpackage

// File: rtl/wb_port_arbiter_side_fifo.sv
// wb_side_fifo: ordered buffer for side-unit register writes.
// Pointers carry one extra wrap bit; full/empty come from the MSB compare.
// busy_mask flags every register targeted by a currently stored entry.
module wb_side_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH  = WbFifoDepth,
    parameter int ADDR_W = RegAddrW,
    parameter int DATA_W = RegDataW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [ADDR_W-1:0]      push_addr,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W-1:0]      head_addr,
    output logic [DATA_W-1:0]      head_data,
    output logic [(2**ADDR_W)-1:0] busy_mask
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [PTR_W-1:0]  w_count;
    logic [IDX_W-1:0]  w_off;
    logic              w_push;
    logic              w_pop;

    assign w_wr_idx  = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx  = r_rd_ptr[IDX_W-1:0];
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) && (w_wr_idx == w_rd_idx);
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;
    assign head_addr = r_addr[w_rd_idx];
    assign head_data = r_data[w_rd_idx];

    // Pointer update; reset discards all queued entries
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[w_wr_idx] <= push_addr;
            r_data[w_wr_idx] <= push_data;
        end
    end

    // Slot i is live when its distance from the read index is below occupancy
    always_comb begin
        busy_mask = '0;
        w_off     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_off = IDX_W'(i) - w_rd_idx;
            if ({1'b0, w_off} < w_count) busy_mask[r_addr[i]] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// pipeline writeback (always wins) and a buffered out-of-order side unit.
// Optional macro WB_SIDE_BYPASS_EN lets a side write skip the empty FIFO when
// the writeback slot is idle.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH      = WbFifoDepth,
    parameter int STARVE_MAX = WbStarveMax,
    parameter int ADDR_W     = RegAddrW,
    parameter int DATA_W     = RegDataW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_we,
    input  logic [ADDR_W-1:0]      pipe_waddr,
    input  logic [DATA_W-1:0]      pipe_wdata,
    input  logic                   side_req,
    input  logic [ADDR_W-1:0]      side_waddr,
    input  logic [DATA_W-1:0]      side_wdata,
    output logic                   side_ready,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [(2**ADDR_W)-1:0] busy_mask,
    output logic                   stall_req
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_stall_req;

    logic              w_pipe_eff;
    logic              w_side_nz;
    logic              w_accept;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    wb_sel_e           w_sel;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [DATA_W-1:0] w_nxt_data;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_pipe_eff = pipe_we && (pipe_waddr != NOPRegAddr[ADDR_W-1:0]);
    assign w_side_nz  = (side_waddr != '0);
    assign side_ready = !w_full;
    assign w_accept   = side_req && side_ready;

`ifdef WB_SIDE_BYPASS_EN
    assign w_bypass = w_accept && w_side_nz && w_empty && !w_pipe_eff;
`else
    assign w_bypass = 1'b0;
`endif

    // Address-0 side writes complete the handshake but are dropped here
    assign w_push = w_accept && w_side_nz && !w_bypass;
    assign w_pop  = (w_sel == WB_SEL_FIFO);

    wb_side_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_side_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_addr (side_waddr),
        .push_data (side_wdata),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head_addr (w_head_addr),
        .head_data (w_head_data),
        .busy_mask (busy_mask)
    );

    // Slot selection: pipeline first, then FIFO head, then direct side bypass
    always_comb begin
        w_sel      = WB_SEL_NONE;
        w_nxt_addr = r_rf_waddr;
        w_nxt_data = r_rf_wdata;
        if (w_pipe_eff) begin
            w_sel      = WB_SEL_PIPE;
            w_nxt_addr = pipe_waddr;
            w_nxt_data = pipe_wdata;
        end else if (!w_empty) begin
            w_sel      = WB_SEL_FIFO;
            w_nxt_addr = w_head_addr;
            w_nxt_data = w_head_data;
        end else if (w_bypass) begin
            w_sel      = WB_SEL_BYPASS;
            w_nxt_addr = side_waddr;
            w_nxt_data = side_wdata;
        end
    end

    // Starvation count: grows only while a queued entry is blocked by the pipe
    always_comb begin
        w_cnt_nxt = r_starve_cnt;
        if (w_pop || w_empty) begin
            w_cnt_nxt = '0;
        end else if (w_pipe_eff && (r_starve_cnt != STARVE_LIM)) begin
            w_cnt_nxt = r_starve_cnt + CNT_W'(1);
        end
    end

    // Registered write port; address/data hold when no write is selected
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable_n) begin
            r_rf_we    <= WriteDisable;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= (w_sel != WB_SEL_NONE) ? WriteEnable : WriteDisable;
            if (w_sel != WB_SEL_NONE) begin
                r_rf_waddr <= w_nxt_addr;
                r_rf_wdata <= w_nxt_data;
            end
        end
    end

    // Starvation counter and registered stall request
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable_n) begin
            r_starve_cnt <= '0;
            r_stall_req  <= 1'b0;
        end else begin
            r_starve_cnt <= w_cnt_nxt;
            r_stall_req  <= (w_cnt_nxt == STARVE_LIM);
        end
    end

    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign stall_req = r_stall_req;

endmodule
